// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder.
package sccb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEVADDR,
      ST_SUBHI,
      ST_SUBLO,
      ST_WRDATA,
      ST_RDDATA,
      ST_RDACK,
      ST_IGNORE
   } sccb_state_e;

   localparam logic [7:0] DEV_ADDR_WR = 8'h78;
   localparam logic [7:0] DEV_ADDR_RD = 8'h79;
   localparam int FILT_LEN_DFLT = 4;

   typedef struct packed {
      logic sda;
      logic scl_rise;
      logic scl_fall;
      logic start;
      logic stop;
   } line_evt_t;

endpackage

// File: rtl/sccb_slave_regif_if.sv
// Register-file side bus of the SCCB responder.
interface sccb_slave_regif_if;

   logic        wr_en;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic [15:0] rd_addr;
   logic [7:0]  rd_data;

   modport master (
      output wr_en,
      output wr_addr,
      output wr_data,
      output rd_addr,
      input  rd_data
   );

   modport slave (
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  rd_addr,
      output rd_data
   );

endinterface

// File: rtl/sccb_slave_regif_line_filter.sv
// SCL/SDA synchronizer, glitch filter and bus-condition pulses.
module sccb_line_filter
   import sccb_pkg::*;
#(
   parameter int FILT_LEN = FILT_LEN_DFLT
) (
   input  logic      clk_25M,
   input  logic      camera_rstn,
   input  logic      scl_in,
   input  logic      sda_in,
   output line_evt_t evt
);

   localparam int CW = $clog2(FILT_LEN + 1);

   // bit 1 = SCL, bit 0 = SDA; idle bus level is high
   logic [1:0]         s1_q;
   logic [1:0]         s2_q;
   logic [1:0]         filt_q;
   logic [1:0]         filt_d;
   logic [1:0]         prev_q;
   logic [1:0][CW-1:0] cnt_q;
   logic [1:0][CW-1:0] cnt_d;

   always_comb begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] == filt_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CW'(FILT_LEN - 1)) begin
            filt_d[i] = s2_q[i];
            cnt_d[i]  = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_25M or negedge camera_rstn) begin
      if (!camera_rstn) begin
         s1_q   <= 2'b11;
         s2_q   <= 2'b11;
         filt_q <= 2'b11;
         prev_q <= 2'b11;
         cnt_q  <= '0;
      end else begin
         s1_q   <= {scl_in, sda_in};
         s2_q   <= s1_q;
         filt_q <= filt_d;
         prev_q <= filt_q;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      evt          = '0;
      evt.sda      = filt_q[0];
      evt.scl_rise = filt_q[1] & ~prev_q[1];
      evt.scl_fall = ~filt_q[1] & prev_q[1];
      evt.start    = filt_q[1] & prev_q[1] & prev_q[0] & ~filt_q[0];
      evt.stop     = filt_q[1] & prev_q[1] & ~prev_q[0] & filt_q[0];
   end

endmodule

// File: rtl/sccb_slave_regif.sv
// SCCB/I2C responder: decodes 0x78 writes into register strobes
// and serves 0x79 reads from an external register file.
module sccb_slave_regif
   import sccb_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h3C,
   parameter int         FILT_LEN = FILT_LEN_DFLT,
   parameter bit         AUTO_INC = 1'b1
) (
   input  logic               clk_25M,
   input  logic               camera_rstn,
   input  logic               i2c_sclk,
   inout  wire                i2c_sdat,
   sccb_slave_regif_if.master regif,
   output logic               busy,
   output logic               nack_err
);

   localparam logic [15:0] PTR_STEP = {15'd0, AUTO_INC};

   line_evt_t evt;

   sccb_line_filter #(
      .FILT_LEN (FILT_LEN)
   ) u_filt (
      .clk_25M     (clk_25M),
      .camera_rstn (camera_rstn),
      .scl_in      (i2c_sclk),
      .sda_in      (i2c_sdat),
      .evt         (evt)
   );

   sccb_state_e state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [15:0] ptr_q, ptr_d;
   logic        sda_oe_q, sda_oe_d;
   logic        ack_ph_q, ack_ph_d;
   logic        inc_pend_q, inc_pend_d;
   logic [1:0]  reload_q, reload_d;
   logic [1:0]  nack_pend_q, nack_pend_d;
   logic        nack_err_q, nack_err_d;
   logic        busy_q, busy_d;
   logic        wr_en_q, wr_en_d;
   logic [15:0] wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      ptr_d       = ptr_q;
      sda_oe_d    = sda_oe_q;
      ack_ph_d    = ack_ph_q;
      inc_pend_d  = 1'b0;
      reload_d    = reload_q;
      nack_pend_d = nack_pend_q;
      nack_err_d  = nack_err_q;
      busy_d      = busy_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;

      if (inc_pend_q) begin
         ptr_d = ptr_q + PTR_STEP;
      end
      // read data is reloaded once the new rd_addr has been looked up
      if (reload_q == 2'd2) begin
         reload_d = 2'd1;
      end else if (reload_q == 2'd1) begin
         shift_d  = regif.rd_data;
         reload_d = 2'd0;
      end

      if (evt.stop) begin
         state_d     = ST_IDLE;
         bit_cnt_d   = '0;
         sda_oe_d    = 1'b0;
         ack_ph_d    = 1'b0;
         nack_pend_d = '0;
         busy_d      = 1'b0;
      end else if (evt.start) begin
         state_d     = ST_DEVADDR;
         bit_cnt_d   = '0;
         sda_oe_d    = 1'b0;
         ack_ph_d    = 1'b0;
         nack_pend_d = '0;
         busy_d      = 1'b1;
      end else begin
         if (evt.scl_rise && !ack_ph_q) begin
            unique case (state_q)
               ST_DEVADDR, ST_SUBHI, ST_SUBLO, ST_WRDATA: begin
                  if (bit_cnt_q < 4'd8) begin
                     shift_d   = {shift_q[6:0], evt.sda};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
               ST_RDDATA: begin
                  if (bit_cnt_q < 4'd8) begin
                     shift_d   = {shift_q[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
               ST_RDACK: begin
                  if (!evt.sda) begin
                     ptr_d    = ptr_q + PTR_STEP;
                     reload_d = 2'd2;
                  end else begin
                     state_d     = ST_IGNORE;
                     nack_pend_d = 2'd1;
                  end
               end
               default: ;
            endcase
         end

         if (evt.scl_fall) begin
            // the fall that ends the NACK clock is normal; any further one is not
            if (nack_pend_q == 2'd1) begin
               nack_pend_d = 2'd2;
            end else if (nack_pend_q == 2'd2) begin
               nack_err_d = 1'b1;
            end

            if (ack_ph_q) begin
               ack_ph_d  = 1'b0;
               bit_cnt_d = '0;
               sda_oe_d  = (state_q == ST_RDDATA) & ~shift_q[7];
            end else if (state_q == ST_RDACK) begin
               state_d   = ST_RDDATA;
               bit_cnt_d = '0;
               sda_oe_d  = ~shift_q[7];
            end else if (bit_cnt_q == 4'd8) begin
               unique case (state_q)
                  ST_DEVADDR: begin
                     if (shift_q[7:1] == DEV_ADDR) begin
                        sda_oe_d = 1'b1;
                        ack_ph_d = 1'b1;
                        if (shift_q[0]) begin
                           state_d = ST_RDDATA;
                           shift_d = regif.rd_data;
                        end else begin
                           state_d = ST_SUBHI;
                        end
                     end else begin
                        state_d = ST_IGNORE;
                     end
                  end
                  ST_SUBHI: begin
                     sda_oe_d    = 1'b1;
                     ack_ph_d    = 1'b1;
                     ptr_d[15:8] = shift_q;
                     state_d     = ST_SUBLO;
                  end
                  ST_SUBLO: begin
                     sda_oe_d   = 1'b1;
                     ack_ph_d   = 1'b1;
                     ptr_d[7:0] = shift_q;
                     state_d    = ST_WRDATA;
                  end
                  ST_WRDATA: begin
                     sda_oe_d   = 1'b1;
                     ack_ph_d   = 1'b1;
                     wr_en_d    = 1'b1;
                     wr_addr_d  = ptr_q;
                     wr_data_d  = shift_q;
                     inc_pend_d = 1'b1;
                  end
                  ST_RDDATA: begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_RDACK;
                  end
                  default: ;
               endcase
            end else if (state_q == ST_RDDATA) begin
               sda_oe_d = ~shift_q[7];
            end
         end
      end
   end

   always_ff @(posedge clk_25M or negedge camera_rstn) begin
      if (!camera_rstn) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         ptr_q       <= '0;
         sda_oe_q    <= 1'b0;
         ack_ph_q    <= 1'b0;
         inc_pend_q  <= 1'b0;
         reload_q    <= '0;
         nack_pend_q <= '0;
         nack_err_q  <= 1'b0;
         busy_q      <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         ptr_q       <= ptr_d;
         sda_oe_q    <= sda_oe_d;
         ack_ph_q    <= ack_ph_d;
         inc_pend_q  <= inc_pend_d;
         reload_q    <= reload_d;
         nack_pend_q <= nack_pend_d;
         nack_err_q  <= nack_err_d;
         busy_q      <= busy_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign i2c_sdat      = sda_oe_q ? 1'b0 : 1'bz;
   assign regif.wr_en   = wr_en_q;
   assign regif.wr_addr = wr_addr_q;
   assign regif.wr_data = wr_data_q;
   assign regif.rd_addr = ptr_q;
   assign busy          = busy_q;
   assign nack_err      = nack_err_q;

endmodule
